sram_arbiter: RTL

- Sequences all accesses to the single external 1M x 16 asset SRAM.
- Shares the SRAM between one loader write port and NUM_RD read requesters. Read requesters are R0 = background/map fetch, then sprite/caption fetchers.
- Fixed priority with starvation escape for reads.
- Load-mode gating: writes are serviced only while assets are being loaded; reads only otherwise.

---
 rtl/sram_arbiter_if.sv | 41 ++++
 rtl/sram_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - request/grant and SRAM pin bundle for sram_arbiter
interface sram_arbiter_if #(
  parameter int NUM_RD = 3,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic                     load_mode;
  logic [NUM_RD-1:0]        rd_req;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_gnt;
  logic [NUM_RD-1:0]        rd_valid;
  logic [DATA_W-1:0]        rd_data;
  logic                     wr_req;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_gnt;
  logic                     wr_done;
  logic [ADDR_W-1:0]        sram_addr;
  logic [DATA_W-1:0]        sram_dq;
  logic                     sram_dq_oe;
  logic [DATA_W-1:0]        sram_dq_in;
  logic                     sram_ce_n;
  logic                     sram_oe_n;
  logic                     sram_we_n;
  logic                     sram_lb_n;
  logic                     sram_ub_n;

  modport master (
    output load_mode, rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_dq_in,
    input  rd_gnt, rd_valid, rd_data, wr_gnt, wr_done,
    input  sram_addr, sram_dq, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
    input  sram_lb_n, sram_ub_n
  );

  modport slave (
    input  load_mode, rd_req, rd_addr, wr_req, wr_addr, wr_data, sram_dq_in,
    output rd_gnt, rd_valid, rd_data, wr_gnt, wr_done,
    output sram_addr, sram_dq, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
    output sram_lb_n, sram_ub_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-cycle SRAM access sequencer shared by one loader writer and NUM_RD readers
module sram_arbiter #(
  parameter int NUM_RD       = 3,
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  sram_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, HOLD} state_t;

  state_t           state;
  logic             cur_wr;
  logic [IDX_W-1:0] cur_port;
  logic [CNT_W-1:0] starve_cnt [NUM_RD];

  logic             rd_any;
  logic             starved_any;
  logic [IDX_W-1:0] prio_win;
  logic [IDX_W-1:0] starved_win;
  logic [IDX_W-1:0] rd_win;
  logic [ADDR_W-1:0] rd_addr_sel;
  logic             arb_edge;
  logic             grant_wr;
  logic             grant_rd;

  // A promoted (starved) port outranks plain priority; lowest index wins within each class.
  always_comb begin
    rd_any      = 1'b0;
    starved_any = 1'b0;
    prio_win    = '0;
    starved_win = '0;
    for (int k = NUM_RD - 1; k >= 0; k--) begin
      if (bus.rd_req[k]) begin
        rd_any   = 1'b1;
        prio_win = IDX_W'(k);
      end
    end
    for (int k = NUM_RD - 1; k >= 1; k--) begin
      if (bus.rd_req[k] && starve_cnt[k] == CNT_W'(STARVE_LIMIT)) begin
        starved_any = 1'b1;
        starved_win = IDX_W'(k);
      end
    end
    rd_win      = starved_any ? starved_win : prio_win;
    rd_addr_sel = bus.rd_addr[int'(rd_win)*ADDR_W +: ADDR_W];
    arb_edge    = (state == IDLE) || (state == HOLD);
    grant_wr    = arb_edge && bus.load_mode && bus.wr_req;
    grant_rd    = arb_edge && !bus.load_mode && rd_any;
  end

  assign bus.sram_lb_n = 1'b0;
  assign bus.sram_ub_n = 1'b0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      cur_wr         <= 1'b0;
      cur_port       <= '0;
      bus.rd_gnt     <= '0;
      bus.rd_valid   <= '0;
      bus.rd_data    <= {DATA_W{1'b0}};
      bus.wr_gnt     <= 1'b0;
      bus.wr_done    <= 1'b0;
      bus.sram_addr  <= '0;
      bus.sram_dq    <= {DATA_W{1'b0}};
      bus.sram_dq_oe <= 1'b0;
      bus.sram_ce_n  <= 1'b1;
      bus.sram_oe_n  <= 1'b1;
      bus.sram_we_n  <= 1'b1;
      for (int k = 0; k < NUM_RD; k++) starve_cnt[k] <= '0;
    end else begin
      bus.rd_gnt   <= '0;
      bus.rd_valid <= '0;
      bus.wr_gnt   <= 1'b0;
      bus.wr_done  <= 1'b0;

      for (int k = 0; k < NUM_RD; k++) begin
        if (k == 0 || !bus.rd_req[k] || (grant_rd && rd_win == IDX_W'(k)))
          starve_cnt[k] <= '0;
        else if (grant_rd && starve_cnt[k] != CNT_W'(STARVE_LIMIT))
          starve_cnt[k] <= starve_cnt[k] + CNT_W'(1);
      end

      case (state)
        SETUP: begin
          state         <= HOLD;
          bus.sram_we_n <= 1'b1;
        end
        IDLE, HOLD: begin
          if (state == HOLD) begin
            if (cur_wr) begin
              bus.wr_done <= 1'b1;
            end else begin
              bus.rd_valid[cur_port] <= 1'b1;
              bus.rd_data            <= bus.sram_dq_in;
            end
          end
          if (grant_wr) begin
            state          <= SETUP;
            cur_wr         <= 1'b1;
            bus.wr_gnt     <= 1'b1;
            bus.sram_addr  <= bus.wr_addr;
            bus.sram_dq    <= bus.wr_data;
            bus.sram_dq_oe <= 1'b1;
            bus.sram_ce_n  <= 1'b0;
            bus.sram_oe_n  <= 1'b1;
            bus.sram_we_n  <= 1'b0;
          end else if (grant_rd) begin
            state              <= SETUP;
            cur_wr             <= 1'b0;
            cur_port           <= rd_win;
            bus.rd_gnt[rd_win] <= 1'b1;
            bus.sram_addr      <= rd_addr_sel;
            bus.sram_dq_oe     <= 1'b0;
            bus.sram_ce_n      <= 1'b0;
            bus.sram_oe_n      <= 1'b0;
            bus.sram_we_n      <= 1'b1;
          end else begin
            state          <= IDLE;
            bus.sram_dq_oe <= 1'b0;
            bus.sram_ce_n  <= 1'b1;
            bus.sram_oe_n  <= 1'b1;
            bus.sram_we_n  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
